pea_slot_scheduler: RTL and testbench

- Owns the shared pool of pea projectile slots that feed the per-slot pixel comparators producing pea_on1..pea_on20.
- Arbitrates fire requests from pea shooter plants, allocates free slots, and advances every live pea once per video frame.
- Frees a slot on zombie hit or when the pea leaves the lawn.
- Sits between the plant grid logic and the pea assembler / collision logic.

---
 rtl/pea_slot_scheduler_pkg.sv | 26 ++
 rtl/pea_slot_scheduler_rr_arbiter.sv | 35 +++
 rtl/pea_slot_scheduler.sv | 131 +++++++++++++
 tb/tb_pea_slot_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pea_slot_scheduler_pkg.sv
// Shared constants and types for the pea projectile slot scheduler.
package pea_pkg;
  localparam int unsigned NUM_SLOTS    = 20;
  localparam int unsigned NUM_SHOOTERS = 8;
  localparam int unsigned COORD_W      = 10;
  localparam int unsigned PEA_SPEED    = 2;
  localparam int unsigned X_LIMIT      = 640;
  localparam logic [23:0] PEA_COLOR    = 24'hF0BC3C;
  localparam int unsigned SLOT_IW      = 5;
  localparam int unsigned SHOOTER_IW   = $clog2(NUM_SHOOTERS);

  typedef enum logic {IDLE, ADVANCE} sched_state_t;

  // Index of the lowest clear bit; 0 when the bitmap is full (caller checks).
  function automatic logic [SLOT_IW-1:0] lowest_free(input logic [NUM_SLOTS-1:0] act);
    logic found;
    lowest_free = '0;
    found       = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!found && !act[i]) begin
        lowest_free = SLOT_IW'(i);
        found       = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/pea_slot_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr, masked requesters are skipped.
module rr_arbiter #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] winner
);
  logic [N-1:0] w_eff;

  assign w_eff = req & ~mask;

  always_comb begin
    logic        found;
    int unsigned idx;
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    if (enable) begin
      for (int unsigned k = 0; k < N; k++) begin
        idx = (32'(ptr) + k) % N;
        if (!found && w_eff[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          winner     = idx[IW-1:0];
        end
      end
    end
  end
endmodule

// File: rtl/pea_slot_scheduler.sv
// Pea slot pool: grants fire requests into free slots, sweeps live peas once per frame,
// and retires peas on zombie hit or when they leave the lawn.
module pea_slot_scheduler
  import pea_pkg::*;
(
  input  logic                              MAX10_CLK1_50,
  input  logic                              Reset_n,
  input  logic                              frame_tick,
  input  logic [NUM_SHOOTERS-1:0]           fire_req,
  input  logic [NUM_SHOOTERS*COORD_W-1:0]   fire_x,
  input  logic [NUM_SHOOTERS*COORD_W-1:0]   fire_y,
  output logic [NUM_SHOOTERS-1:0]           fire_ack,
  input  logic                              hit_valid,
  input  logic [4:0]                        hit_slot,
  output logic [NUM_SLOTS-1:0]              slot_active,
  output logic [NUM_SLOTS*COORD_W-1:0]      slot_x,
  output logic [NUM_SLOTS*COORD_W-1:0]      slot_y,
  output logic                              pool_full,
  output logic                              advancing
);
  localparam logic [COORD_W:0]   XLIM  = (COORD_W+1)'(X_LIMIT);
  localparam logic [COORD_W:0]   SPEED = (COORD_W+1)'(PEA_SPEED);
  localparam logic [SLOT_IW-1:0] LAST  = SLOT_IW'(NUM_SLOTS - 1);
  localparam logic [SLOT_IW-1:0] NSLOT = SLOT_IW'(NUM_SLOTS);

  sched_state_t                 r_state, w_state_nxt;
  logic [SLOT_IW-1:0]           r_idx, w_idx_nxt;
  logic                         r_tick_pending, w_pending_nxt;
  logic [SHOOTER_IW-1:0]        r_ptr, w_ptr_nxt;
  logic [NUM_SHOOTERS-1:0]      r_ack, w_grant;
  logic [SHOOTER_IW-1:0]        w_winner;
  logic [NUM_SLOTS-1:0]         r_active, w_active_nxt;
  logic [NUM_SLOTS*COORD_W-1:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic [SLOT_IW-1:0]           w_free_idx;
  logic                         w_free_found, w_arb_en, w_granted, w_last;
  logic [COORD_W:0]             w_nx;

  // Allocation works off the registered bitmap, so a hit-freed slot is only visible next cycle.
  assign w_free_found = ~&r_active;
  assign w_free_idx   = lowest_free(r_active);
  assign w_arb_en     = (r_state == IDLE) && !frame_tick && w_free_found;
  assign w_granted    = |w_grant;
  assign w_last       = (r_idx == LAST);
  assign w_nx         = {1'b0, r_x[32'(r_idx)*COORD_W +: COORD_W]} + SPEED;

  rr_arbiter #(.N(NUM_SHOOTERS), .IW(SHOOTER_IW)) u_arb (
    .req    (fire_req),
    .mask   (r_ack),
    .ptr    (r_ptr),
    .enable (w_arb_en),
    .grant  (w_grant),
    .winner (w_winner)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_pending_nxt = r_tick_pending;
    unique case (r_state)
      IDLE: begin
        if (frame_tick) begin
          w_state_nxt = ADVANCE;
          w_idx_nxt   = '0;
        end
      end
      ADVANCE: begin
        if (frame_tick) w_pending_nxt = 1'b1;
        if (w_last) begin
          w_idx_nxt = '0;
          if (r_tick_pending || frame_tick) w_pending_nxt = 1'b0;
          else                              w_state_nxt   = IDLE;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_granted)
      w_ptr_nxt = (w_winner == SHOOTER_IW'(NUM_SHOOTERS - 1)) ? '0 : w_winner + 1'b1;
  end

  // Order matters: sweep, then grant, then hit, so a hit overrides the sweep on the same slot.
  always_comb begin
    w_active_nxt = r_active;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    if (r_state == ADVANCE && r_active[r_idx]) begin
      if (w_nx >= XLIM) w_active_nxt[r_idx] = 1'b0;
      else              w_x_nxt[32'(r_idx)*COORD_W +: COORD_W] = w_nx[COORD_W-1:0];
    end
    if (w_granted) begin
      w_active_nxt[w_free_idx]                    = 1'b1;
      w_x_nxt[32'(w_free_idx)*COORD_W +: COORD_W] = fire_x[32'(w_winner)*COORD_W +: COORD_W];
      w_y_nxt[32'(w_free_idx)*COORD_W +: COORD_W] = fire_y[32'(w_winner)*COORD_W +: COORD_W];
    end
    if (hit_valid && (hit_slot < NSLOT)) w_active_nxt[hit_slot] = 1'b0;
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state        <= IDLE;
      r_idx          <= '0;
      r_tick_pending <= 1'b0;
      r_ptr          <= '0;
      r_ack          <= '0;
      r_active       <= '0;
      r_x            <= '0;
      r_y            <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_idx          <= w_idx_nxt;
      r_tick_pending <= w_pending_nxt;
      r_ptr          <= w_ptr_nxt;
      r_ack          <= w_grant;
      r_active       <= w_active_nxt;
      r_x            <= w_x_nxt;
      r_y            <= w_y_nxt;
    end
  end

  assign fire_ack    = r_ack;
  assign slot_active = r_active;
  assign slot_x      = r_x;
  assign slot_y      = r_y;
  assign pool_full   = &r_active;
  assign advancing   = (r_state == ADVANCE);
endmodule

// File: tb/tb_pea_slot_scheduler.sv
// Directed bench for pea_slot_scheduler; grants are checked against a queue of predicted grants.
module tb_pea_slot_scheduler;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         frame_tick;
  logic [7:0]   fire_req;
  logic [79:0]  fire_x, fire_y;
  logic [7:0]   fire_ack;
  logic         hit_valid;
  logic [4:0]   hit_slot;
  logic [19:0]  slot_active;
  logic [199:0] slot_x, slot_y;
  logic         pool_full, advancing;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  int unsigned adv_cnt;

  typedef struct {
    int unsigned w;
    int unsigned s;
    logic [9:0]  x;
    logic [9:0]  y;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  pea_slot_scheduler dut (
    .MAX10_CLK1_50 (clk),
    .Reset_n       (rst_n),
    .frame_tick    (frame_tick),
    .fire_req      (fire_req),
    .fire_x        (fire_x),
    .fire_y        (fire_y),
    .fire_ack      (fire_ack),
    .hit_valid     (hit_valid),
    .hit_slot      (hit_slot),
    .slot_active   (slot_active),
    .slot_x        (slot_x),
    .slot_y        (slot_y),
    .pool_full     (pool_full),
    .advancing     (advancing)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] sx(input int unsigned s);
    return slot_x[s*10 +: 10];
  endfunction

  function automatic logic [9:0] sy(input int unsigned s);
    return slot_y[s*10 +: 10];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_shooter(input int unsigned w, input logic [9:0] x, input logic [9:0] y);
    fire_x[w*10 +: 10] = x;
    fire_y[w*10 +: 10] = y;
  endtask

  task automatic expect_grant(input int unsigned w, input int unsigned s,
                              input logic [9:0] x, input logic [9:0] y);
    exp_t e;
    e.w = w; e.s = s; e.x = x; e.y = y;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    fire_req   = '0;
    fire_x     = '0;
    fire_y     = '0;
    hit_valid  = 1'b0;
    hit_slot   = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && fire_ack != '0) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_ack", 32'(fire_ack), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_ack", 32'(fire_ack), 32'd1 << mon_e.w);
        chk("sb_active", 32'(slot_active[mon_e.s]), 32'd1);
        chk("sb_x", 32'(sx(mon_e.s)), 32'(mon_e.x));
        chk("sb_y", 32'(sy(mon_e.s)), 32'(mon_e.y));
      end
    end
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_active", 32'(slot_active), 32'd0);
    chk("rst_ack", 32'(fire_ack), 32'd0);
    chk("rst_full", 32'(pool_full), 32'd0);
    chk("rst_adv", 32'(advancing), 32'd0);
    chk("rst_xy_zero", 32'((slot_x == '0) && (slot_y == '0)), 32'd1);

    // Single request, one-cycle latency
    set_shooter(3, 10'd100, 10'd200);
    fire_req = 8'h08;
    expect_grant(3, 0, 10'd100, 10'd200);
    tick();
    chk("t1_ack", 32'(fire_ack), 32'h08);
    chk("t1_active", 32'(slot_active), 32'h1);
    chk("t1_x", 32'(sx(0)), 32'd100);
    chk("t1_y", 32'(sy(0)), 32'd200);
    fire_req = '0;
    tick();
    chk("t1_ack_pulse", 32'(fire_ack), 32'd0);

    // All shooters requesting: round-robin order from pointer 0
    do_reset();
    for (int unsigned i = 0; i < 8; i++) begin
      set_shooter(i, 10'(10 + i), 10'(20 + i));
      expect_grant(i, i, 10'(10 + i), 10'(20 + i));
    end
    fire_req = 8'hFF;
    for (int unsigned i = 0; i < 8; i++) begin
      tick();
      chk("t2_rr_ack", 32'(fire_ack), 32'd1 << i);
      fire_req = fire_req & ~fire_ack;
    end
    tick();
    chk("t2_idle_ack", 32'(fire_ack), 32'd0);
    chk("t2_active", 32'(slot_active), 32'hFF);

    // Fill the pool with a held request (grant every other cycle), then free by hit
    set_shooter(0, 10'd300, 10'd50);
    for (int unsigned s = 8; s < 20; s++) expect_grant(0, s, 10'd300, 10'd50);
    fire_req = 8'h01;
    for (int unsigned k = 0; k < 12; k++) begin
      tick();
      chk("t3_held_ack", 32'(fire_ack), 32'h01);
      tick();
      chk("t3_masked_ack", 32'(fire_ack), 32'd0);
    end
    chk("t3_full", 32'(pool_full), 32'd1);
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      chk("t3_full_noack", 32'(fire_ack), 32'd0);
    end
    hit_valid = 1'b1;
    hit_slot  = 5'd5;
    tick();
    hit_valid = 1'b0;
    chk("t3_hit_clear", 32'(slot_active), 32'hFFFDF);
    chk("t3_hit_same_cycle_noack", 32'(fire_ack), 32'd0);
    chk("t3_not_full", 32'(pool_full), 32'd0);
    expect_grant(0, 5, 10'd300, 10'd50);
    tick();
    chk("t3_regrant", 32'(fire_ack), 32'h01);
    chk("t3_refull", 32'(pool_full), 32'd1);
    fire_req = '0;
    tick();

    // Frame sweep: 20 cycles of advancing, grants deferred until IDLE
    do_reset();
    set_shooter(0, 10'd637, 10'd11);
    set_shooter(1, 10'd100, 10'd12);
    expect_grant(0, 0, 10'd637, 10'd11);
    expect_grant(1, 1, 10'd100, 10'd12);
    fire_req = 8'h03;
    tick();
    fire_req = fire_req & ~fire_ack;
    tick();
    chk("t4_setup_ack", 32'(fire_ack), 32'h02);
    fire_req = '0;
    set_shooter(2, 10'd50, 10'd60);
    expect_grant(2, 2, 10'd50, 10'd60);
    fire_req   = 8'h04;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      chk("t4_adv_high", 32'(advancing), 32'd1);
      chk("t4_no_grant", 32'(fire_ack), 32'd0);
      tick();
    end
    chk("t4_adv_low", 32'(advancing), 32'd0);
    chk("t4_no_grant_last", 32'(fire_ack), 32'd0);
    chk("t4_x0_639", 32'(sx(0)), 32'd639);
    chk("t4_x0_live", 32'(slot_active[0]), 32'd1);
    chk("t4_x1_102", 32'(sx(1)), 32'd102);
    tick();
    chk("t4_deferred_grant", 32'(fire_ack), 32'h04);
    fire_req = '0;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    repeat (20) tick();
    chk("t4_retired", 32'(slot_active), 32'h6);
    chk("t4_x1_104", 32'(sx(1)), 32'd104);
    chk("t4_x2_52", 32'(sx(2)), 32'd52);

    // Tick during sweep queues one more sweep; a third tick is dropped
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    adv_cnt = 0;
    for (int unsigned i = 0; i < 70; i++) begin
      if (advancing) adv_cnt++;
      if (i == 4 || i == 9) frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
    end
    chk("t5_adv_cycles", adv_cnt, 32'd40);
    chk("t5_x1_108", 32'(sx(1)), 32'd108);
    chk("t5_x2_56", 32'(sx(2)), 32'd56);

    // Hit vs sweep on slot 0, out-of-range hit, async reset mid-sweep
    set_shooter(4, 10'd200, 10'd70);
    expect_grant(4, 0, 10'd200, 10'd70);
    fire_req = 8'h10;
    tick();
    fire_req = '0;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    hit_valid  = 1'b1;
    hit_slot   = 5'd0;
    tick();
    chk("t6_hit_wins", 32'(slot_active), 32'h6);
    hit_slot = 5'd25;
    tick();
    hit_valid = 1'b0;
    chk("t6_hit_oob", 32'(slot_active), 32'h6);
    repeat (3) tick();
    chk("t6_mid_sweep", 32'(advancing), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_arst_adv", 32'(advancing), 32'd0);
    chk("t6_arst_active", 32'(slot_active), 32'd0);
    chk("t6_arst_xy", 32'((slot_x == '0) && (slot_y == '0)), 32'd1);
    chk("t6_arst_ack_full", 32'({fire_ack, pool_full}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("t6_post_rst_adv", 32'(advancing), 32'd0);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
